slot_bank_buffer: RTL and testbench

- Double-banked (ping-pong) slot memory for the 8x8 crossbar.
- Sits directly downstream of the crossbar control logic and consumes its timing outputs: bank_sel, mux_sel, swdone, mem_clr, load and running_slot.
- The write bank is filled serially, one port/slot entry per cycle.
- The read bank is presented in parallel, all ports at once, one slot per load pulse.

---
 rtl/xbar_pkg.sv | 22 ++
 rtl/slot_bank.sv | 58 +++++
 rtl/slot_bank_buffer.sv | 103 ++++++++++
 tb/tb_slot_bank_buffer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared constants, index-width helpers and entry type for the crossbar slot memory.
// No logic; elaboration-time only.
// No flow control.
package xbar_pkg;

    localparam int CLR_CYC = 4;
    localparam int DEF_DW  = 8;

    function automatic int entry_w(input int ports, input int slots);
        return (ports * slots > 1) ? $clog2(ports * slots) : 1;
    endfunction

    function automatic int count_w(input int ports, input int slots);
        return $clog2(ports * slots) + 1;
    endfunction

    typedef struct packed {
        logic              vld;
        logic [DEF_DW-1:0] data;
    } slot_entry_t;

endpackage

// File: rtl/slot_bank.sv
// One slot-memory bank: serial write port, parallel all-port read of one slot, port-group clear.
// Write/clear take effect at the next clock edge; read path is combinational.
// No backpressure; the parent gates we/clr_en.
module slot_bank
    import xbar_pkg::*;
#(
    parameter int PORTS = 8,
    parameter int SLOTS = 4,
    parameter int DW    = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                we,
    input  logic [entry_w(PORTS, SLOTS)-1:0]    waddr,
    input  logic [DW-1:0]                       wdata,
    output logic                                hit,
    input  logic                                clr_en,
    input  logic [$clog2(CLR_CYC)-1:0]          clr_grp,
    input  logic [$clog2(SLOTS)-1:0]            rd_slot,
    output logic [PORTS*DW-1:0]                 rd_data,
    output logic [PORTS-1:0]                    rd_vld
);

    localparam int NE  = PORTS * SLOTS;
    localparam int EW  = entry_w(PORTS, SLOTS);
    localparam int GRP = PORTS / CLR_CYC;

    logic [DW-1:0] data_mem [NE];
    logic [NE-1:0] vld_mem;

    always_ff @(posedge clk) begin
        if (we) data_mem[waddr] <= wdata;
    end

    // Clear and write never hit the same bank in one cycle, so the write simply wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_mem <= '0;
        end else begin
            for (int i = 0; i < NE; i++) begin
                if (clr_en && ((i / SLOTS) / GRP) == int'(clr_grp)) vld_mem[i] <= 1'b0;
            end
            if (we) vld_mem[waddr] <= 1'b1;
        end
    end

    assign hit = vld_mem[waddr];

    always_comb begin
        rd_data = '0;
        rd_vld  = '0;
        for (int p = 0; p < PORTS; p++) begin
            rd_data[p*DW +: DW] = data_mem[EW'(p * SLOTS) + EW'(rd_slot)];
            rd_vld[p]           = vld_mem[EW'(p * SLOTS) + EW'(rd_slot)];
        end
    end

endmodule

// File: rtl/slot_bank_buffer.sv
// Ping-pong slot memory behind the 8x8 crossbar control: serial fill of one bank, parallel slot read of the other.
// Read outputs register one cycle after load and hold; write/clear effects land on the next edge.
// No backpressure; blocked or out-of-range writes are dropped.
module slot_bank_buffer
    import xbar_pkg::*;
#(
    parameter int PORTS = 8,
    parameter int SLOTS = 4,
    parameter int DW    = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                bank_sel,
    input  logic [entry_w(PORTS, SLOTS)-1:0]    mux_sel,
    input  logic                                wr_valid,
    input  logic [DW-1:0]                       wr_data,
    input  logic                                swdone,
    input  logic                                mem_clr,
    input  logic                                load,
    input  logic [$clog2(SLOTS)-1:0]            running_slot,
    output logic [PORTS*DW-1:0]                 rd_data,
    output logic [PORTS-1:0]                    rd_valid,
    output logic [count_w(PORTS, SLOTS)-1:0]    wr_count,
    output logic                                overflow_err,
    output logic                                clr_done
);

    localparam int CW = count_w(PORTS, SLOTS);
    localparam int SW = $clog2(SLOTS);
    localparam int GW = $clog2(CLR_CYC);
    localparam logic [CW-1:0] NE_C      = CW'(PORTS * SLOTS);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);
    localparam logic [GW-1:0] CLR_LAST  = GW'(CLR_CYC - 1);

    logic                bank_sel_q;
    logic                toggle;
    logic                accept;
    logic [SW-1:0]       nslot;
    logic [GW-1:0]       clr_cnt;
    logic                b_hit     [2];
    logic [PORTS*DW-1:0] b_rd_data [2];
    logic [PORTS-1:0]    b_rd_vld  [2];

    assign toggle = bank_sel ^ bank_sel_q;
    assign accept = wr_valid && !swdone && !mem_clr && (CW'(mux_sel) < NE_C);
    assign nslot  = (running_slot == SLOT_LAST) ? '0 : running_slot + 1'b1;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        slot_bank #(
            .PORTS (PORTS),
            .SLOTS (SLOTS),
            .DW    (DW)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .we      (accept && (bank_sel == 1'(b))),
            .waddr   (mux_sel),
            .wdata   (wr_data),
            .hit     (b_hit[b]),
            .clr_en  (mem_clr && (bank_sel != 1'(b))),
            .clr_grp (clr_cnt),
            .rd_slot (nslot),
            .rd_data (b_rd_data[b]),
            .rd_vld  (b_rd_vld[b])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_sel_q   <= 1'b0;
            wr_count     <= '0;
            overflow_err <= 1'b0;
            clr_done     <= 1'b0;
            clr_cnt      <= '0;
            rd_data      <= '0;
            rd_valid     <= '0;
        end else begin
            bank_sel_q <= bank_sel;

            // A bank swap restarts the fill count even if a write lands in the same cycle.
            if (toggle)                             wr_count <= '0;
            else if (accept && wr_count != NE_C)    wr_count <= wr_count + 1'b1;

            if (accept && b_hit[bank_sel]) overflow_err <= 1'b1;

            if (mem_clr) begin
                if (clr_cnt != CLR_LAST) clr_cnt <= clr_cnt + 1'b1;
            end else begin
                clr_cnt <= '0;
            end

            if (toggle)                             clr_done <= 1'b0;
            else if (mem_clr && clr_cnt == CLR_LAST) clr_done <= 1'b1;

            // Captures the pre-edge bank contents, so a same-cycle clear is not yet visible.
            if (load) begin
                rd_data  <= b_rd_data[~bank_sel];
                rd_valid <= b_rd_vld[~bank_sel];
            end
        end
    end

endmodule

// File: tb/tb_slot_bank_buffer.sv
// Directed bench for slot_bank_buffer: scoreboard of expected slot reads plus status checks.
module tb_slot_bank_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bank_sel = 1'b0;
    logic [4:0]  mux_sel = '0;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        swdone = 1'b0;
    logic        mem_clr = 1'b0;
    logic        load = 1'b0;
    logic [1:0]  running_slot = '0;
    logic [63:0] rd_data;
    logic [7:0]  rd_valid;
    logic [5:0]  wr_count;
    logic        overflow_err;
    logic        clr_done;

    slot_bank_buffer #(.PORTS(8), .SLOTS(4), .DW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bank_sel     (bank_sel),
        .mux_sel      (mux_sel),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .swdone       (swdone),
        .mem_clr      (mem_clr),
        .load         (load),
        .running_slot (running_slot),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .wr_count     (wr_count),
        .overflow_err (overflow_err),
        .clr_done     (clr_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [63:0] dat;
        logic [7:0]  vld;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    logic    load_seen = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] pat(input logic [7:0] base);
        logic [63:0] r;
        r = '0;
        for (int p = 0; p < 8; p++) r[p*8 +: 8] = base + 8'(p);
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) load_seen <= 1'b0;
        else     load_seen <= load;
    end

    // Monitor: every registered read is checked against the oldest expectation.
    always @(negedge clk) begin
        if (load_seen && !rst) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_read: rd_valid=%h with no expectation queued", rd_valid);
            end else begin
                rd_exp_t     e;
                logic [63:0] m;
                e = exp_q.pop_front();
                m = '0;
                for (int p = 0; p < 8; p++) if (e.vld[p]) m[p*8 +: 8] = 8'hFF;
                chk({e.name, "_vld"}, 64'(rd_valid), 64'(e.vld));
                chk({e.name, "_dat"}, rd_data & m, e.dat & m);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        mux_sel  = a;
        wr_data  = d;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input string nm, input logic [1:0] rs, input logic [63:0] d, input logic [7:0] v);
        rd_exp_t e;
        e.name = nm;
        e.dat  = d;
        e.vld  = v;
        exp_q.push_back(e);
        load         = 1'b1;
        running_slot = rs;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        // Reset state
        #2;
        chk("rst_rd_data",  rd_data, 64'h0);
        chk("rst_rd_valid", 64'(rd_valid), 64'h0);
        chk("rst_wr_count", 64'(wr_count), 64'h0);
        chk("rst_overflow", 64'(overflow_err), 64'h0);
        chk("rst_clr_done", 64'(clr_done), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset mid-operation
        bank_sel = 1'b0;
        wr(5'd1, 8'h11); wr(5'd5, 8'h15); wr(5'd9, 8'h19); wr(5'd13, 8'h1D); wr(5'd1, 8'h12);
        chk("pre_rst_count", 64'(wr_count), 64'd5);
        chk("pre_rst_ovf",   64'(overflow_err), 64'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_count", 64'(wr_count), 64'd0);
        chk("async_rst_ovf",   64'(overflow_err), 64'd0);
        chk("async_rst_vld",   64'(rd_valid), 64'd0);
        chk("async_rst_clr",   64'(clr_done), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        bank_sel = 1'b1;
        cyc();
        rd("post_rst", 2'd0, 64'h0, 8'h00);

        // Fill bank 0, then swap
        bank_sel = 1'b0;
        cyc();
        for (int p = 0; p < 8; p++) wr(5'(p*4 + 1), 8'h10 + 8'(p));
        chk("fill_count", 64'(wr_count), 64'd8);
        chk("fill_ovf",   64'(overflow_err), 64'd0);
        for (int p = 0; p < 8; p++) begin
            wr(5'(p*4), 8'h20 + 8'(p));
            wr(5'(p*4 + 3), 8'h30 + 8'(p));
        end
        chk("fill_count24", 64'(wr_count), 64'd24);
        bank_sel = 1'b1;
        wr(5'd7, 8'hA1);
        chk("swap_count", 64'(wr_count), 64'd0);
        chk("swap_ovf",   64'(overflow_err), 64'd0);
        rd("swap",  2'd0, pat(8'h10), 8'hFF);
        rd("wrap",  2'd3, pat(8'h20), 8'hFF);
        rd("slot3", 2'd2, pat(8'h30), 8'hFF);

        // Overflow and blocked writes into bank 1
        wr(5'd7, 8'hA2);
        chk("ovf_set",   64'(overflow_err), 64'd1);
        chk("ovf_count", 64'(wr_count), 64'd1);
        swdone = 1'b1;
        wr(5'd8, 8'h55); wr(5'd9, 8'h56);
        swdone = 1'b0;
        chk("swdone_count", 64'(wr_count), 64'd1);
        cyc();
        chk("ovf_sticky", 64'(overflow_err), 64'd1);
        bank_sel = 1'b0;
        cyc();
        chk("ovf_after_swap", 64'(overflow_err), 64'd1);
        rd("ovf_data", 2'd2, 64'h0000_0000_0000_A200, 8'h02);
        rd("blocked",  2'd3, 64'h0, 8'h00);

        // Full clear window with coincident load on the first clear cycle
        bank_sel = 1'b1;
        cyc();
        for (int p = 0; p < 8; p++) wr(5'(p*4), 8'h40 + 8'(p));
        bank_sel = 1'b0;
        cyc();
        mem_clr = 1'b1;
        rd("clr_first", 2'd3, pat(8'h40), 8'hFF);
        cyc();
        cyc();
        chk("clr_done_early", 64'(clr_done), 64'd0);
        cyc();
        mem_clr = 1'b0;
        chk("clr_done_full", 64'(clr_done), 64'd1);
        rd("cleared", 2'd3, 64'h0, 8'h00);

        // Short clear window
        bank_sel = 1'b1;
        cyc();
        chk("clr_done_swap", 64'(clr_done), 64'd0);
        for (int p = 0; p < 8; p++) wr(5'(p*4), 8'h50 + 8'(p));
        bank_sel = 1'b0;
        cyc();
        mem_clr = 1'b1;
        cyc(); cyc(); cyc();
        mem_clr = 1'b0;
        cyc();
        chk("clr_done_short", 64'(clr_done), 64'd0);
        rd("short_clr", 2'd3, pat(8'h50), 8'hC0);

        cyc();
        cyc();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
